// File: rtl/usb_pkg.sv
// Shared USB definitions for the RX and TX packet FSMs: PID and SYNC bytes,
// the packet-type code reported to the protocol controller, and the CRC16 helper.
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_OUT   = 8'hE1;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_ACK   = 3'd2,
        PKT_NAK   = 3'd3,
        PKT_IN    = 3'd4,
        PKT_OUT   = 3'd5
    } rx_packet_t;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Bits enter LSB first, matching their order on the wire.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        return c;
    endfunction

    function automatic rx_packet_t pid_decode(input logic [7:0] pid);
        rx_packet_t pkt;
        pkt = PKT_NONE;
        if (pid[7:4] == ~pid[3:0]) begin
            case (pid)
                PID_DATA0: pkt = PKT_DATA0;
                PID_ACK:   pkt = PKT_ACK;
                PID_NAK:   pkt = PKT_NAK;
                PID_IN:    pkt = PKT_IN;
                PID_OUT:   pkt = PKT_OUT;
                default:   pkt = PKT_NONE;
            endcase
        end
        return pkt;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Byte-wide USB CRC16 accumulator with synchronous clear and update enable.
// Instantiated by usb_rx_fsm only when USB_RX_CRC_CHECK_EN is defined.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= CRC16_INIT;
        end else if (enable) begin
            crc <= crc16_next(crc, data);
        end
    end

endmodule

// File: rtl/usb_rx_fsm.sv
// USB full-speed receive packet controller: SYNC/PID check, token field capture,
// payload streaming with CRC stripping. Define USB_RX_CRC_CHECK_EN to verify CRC16.
module usb_rx_fsm
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] rx_byte,
    input  logic       eop,
    input  logic       bit_error,
    input  logic       buffer_full,
    output logic       store_rx_data,
    output logic [7:0] rx_data,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_error,
    output logic [6:0] rx_data_size,
    output logic       rx_transfer_active,
    output logic [6:0] token_addr,
    output logic [3:0] token_endp,
    output logic [2:0] state_val
);

    // Low three bits are the debug code, so state_val is a direct flop tap.
    typedef enum logic [3:0] {
        S_IDLE     = 4'h0,
        S_PID      = 4'h1,
        S_TOK1     = 4'h2,
        S_TOK2     = 4'hA,
        S_DATA     = 4'h3,
        S_ERR      = 4'h5,
        S_WAIT_EOP = 4'h6,
        S_DONE     = 4'h7
    } state_t;

    localparam logic [6:0] MAX_COUNT = 7'(MAX_DATA_BYTES);

    state_t     state;
    logic [7:0] h0;
    logic [7:0] h1;
    logic       h0_v;
    logic       h1_v;
    logic [6:0] count;
    logic       prev_bit7;
    logic       eop_pend;
    logic       eop_now;
    logic       crc_ok;
    rx_packet_t pid_pkt;

    // A byte coinciding with eop is handled first; the eop is replayed next cycle.
    assign eop_now   = eop_pend | (eop & ~byte_valid);
    assign pid_pkt   = pid_decode(rx_byte);
    assign state_val = state[2:0];

`ifdef USB_RX_CRC_CHECK_EN
    logic [15:0] crc;
    logic        crc_clear;
    logic        crc_en;

    assign crc_clear = (state == S_IDLE);
    assign crc_en    = (state == S_DATA) && byte_valid && !bit_error;

    usb_crc16_byte u_crc16 (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .data   (rx_byte),
        .crc    (crc)
    );

    assign crc_ok = (crc == CRC16_RESIDUAL);
`else
    assign crc_ok = 1'b1;
`endif

    // NOTE: every register here uses <= so all next-state terms see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            h0                 <= '0;
            h1                 <= '0;
            h0_v               <= 1'b0;
            h1_v               <= 1'b0;
            count              <= '0;
            prev_bit7          <= 1'b0;
            eop_pend           <= 1'b0;
            store_rx_data      <= 1'b0;
            rx_data            <= '0;
            rx_packet          <= PKT_NONE;
            rx_data_ready      <= 1'b0;
            rx_error           <= 1'b0;
            rx_data_size       <= '0;
            rx_transfer_active <= 1'b0;
            token_addr         <= '0;
            token_endp         <= '0;
        end else begin
            store_rx_data <= 1'b0;
            rx_data_ready <= 1'b0;
            rx_error      <= 1'b0;
            eop_pend      <= eop & byte_valid;

            if (bit_error && state != S_IDLE && state != S_ERR) begin
                state              <= S_ERR;
                rx_error           <= 1'b1;
                rx_transfer_active <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_valid) begin
                            if (rx_byte == SYNC_BYTE) begin
                                state              <= S_PID;
                                rx_transfer_active <= 1'b1;
                                rx_packet          <= PKT_NONE;
                                count              <= '0;
                                h0_v               <= 1'b0;
                                h1_v               <= 1'b0;
                            end else begin
                                state    <= S_ERR;
                                rx_error <= 1'b1;
                            end
                        end
                    end

                    S_PID: begin
                        if (byte_valid) begin
                            rx_packet <= pid_pkt;
                            case (pid_pkt)
                                PKT_DATA0:        state <= S_DATA;
                                PKT_ACK, PKT_NAK: state <= S_WAIT_EOP;
                                PKT_IN, PKT_OUT:  state <= S_TOK1;
                                default: begin
                                    state              <= S_ERR;
                                    rx_error           <= 1'b1;
                                    rx_transfer_active <= 1'b0;
                                end
                            endcase
                        end else if (eop_now) begin
                            state              <= S_ERR;
                            rx_error           <= 1'b1;
                            rx_transfer_active <= 1'b0;
                        end
                    end

                    S_DATA: begin
                        if (byte_valid) begin
                            if (h0_v && h1_v) begin
                                if (buffer_full || count == MAX_COUNT) begin
                                    state              <= S_ERR;
                                    rx_error           <= 1'b1;
                                    rx_transfer_active <= 1'b0;
                                end else begin
                                    store_rx_data <= 1'b1;
                                    rx_data       <= h1;
                                    h1            <= h0;
                                    h0            <= rx_byte;
                                    count         <= count + 7'd1;
                                end
                            end else begin
                                h1   <= h0;
                                h1_v <= h0_v;
                                h0   <= rx_byte;
                                h0_v <= 1'b1;
                            end
                        end else if (eop_now) begin
                            // The two held bytes are the CRC and are never written out.
                            if (h0_v && h1_v && crc_ok) begin
                                state              <= S_DONE;
                                rx_data_ready      <= 1'b1;
                                rx_data_size       <= count;
                                rx_transfer_active <= 1'b0;
                            end else begin
                                state              <= S_ERR;
                                rx_error           <= 1'b1;
                                rx_transfer_active <= 1'b0;
                            end
                        end
                    end

                    S_TOK1: begin
                        if (byte_valid) begin
                            token_addr <= rx_byte[6:0];
                            prev_bit7  <= rx_byte[7];
                            state      <= S_TOK2;
                        end else if (eop_now) begin
                            state              <= S_ERR;
                            rx_error           <= 1'b1;
                            rx_transfer_active <= 1'b0;
                        end
                    end

                    S_TOK2: begin
                        if (byte_valid) begin
                            token_endp <= {rx_byte[2:0], prev_bit7};
                            state      <= S_WAIT_EOP;
                        end else if (eop_now) begin
                            state              <= S_ERR;
                            rx_error           <= 1'b1;
                            rx_transfer_active <= 1'b0;
                        end
                    end

                    S_WAIT_EOP: begin
                        if (byte_valid) begin
                            state              <= S_ERR;
                            rx_error           <= 1'b1;
                            rx_transfer_active <= 1'b0;
                        end else if (eop_now) begin
                            state              <= S_DONE;
                            rx_data_ready      <= 1'b1;
                            rx_data_size       <= count;
                            rx_transfer_active <= 1'b0;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    S_ERR: begin
                        if (eop_now) begin
                            state <= S_IDLE;
                        end
                    end

                    default: begin
                        state              <= S_ERR;
                        rx_error           <= 1'b1;
                        rx_transfer_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_fsm.sv
// Directed bench for usb_rx_fsm: DATA/handshake/token packets, malformed PID,
// overflow, buffer_full back-pressure, bit_error and mid-packet reset.
module tb_usb_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       eop = 1'b0;
    logic       bit_error = 1'b0;
    logic       buffer_full = 1'b0;

    logic       store_rx_data;
    logic [7:0] rx_data;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_error;
    logic [6:0] rx_data_size;
    logic       rx_transfer_active;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic [2:0] state_val;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    usb_rx_fsm #(.MAX_DATA_BYTES(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .byte_valid         (byte_valid),
        .rx_byte            (rx_byte),
        .eop                (eop),
        .bit_error          (bit_error),
        .buffer_full        (buffer_full),
        .store_rx_data      (store_rx_data),
        .rx_data            (rx_data),
        .rx_packet          (rx_packet),
        .rx_data_ready      (rx_data_ready),
        .rx_error           (rx_error),
        .rx_data_size       (rx_data_size),
        .rx_transfer_active (rx_transfer_active),
        .token_addr         (token_addr),
        .token_endp         (token_endp),
        .state_val          (state_val)
    );

    // Monitor: collects strobed payload and pulse counts on the falling edge.
    logic [7:0] strobes[$];
    int         n_ready = 0;
    int         n_err   = 0;
    logic [6:0] ready_size = 7'd0;

    always @(negedge clk) begin
        if (store_rx_data) strobes.push_back(rx_data);
        if (rx_data_ready) begin
            n_ready++;
            ready_size = rx_data_size;
        end
        if (rx_error) n_err++;
    end

    always @(posedge clk) begin
        assert (!(byte_valid && eop)) else $error("byte_valid and eop asserted together");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({store_rx_data, rx_data, rx_packet, rx_data_ready, rx_error,
                    rx_data_size, rx_transfer_active, token_addr, token_endp, state_val});
    endfunction

    function automatic logic [15:0] crc16_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            fb = c[15] ^ d[k];
            c  = c << 1;
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = x[7 - k];
        return r;
    endfunction

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic put_eop();
        @(negedge clk);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
    endtask

    task automatic put_bit_error();
        @(negedge clk);
        bit_error = 1'b1;
        @(negedge clk);
        bit_error = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // SYNC, DATA0, n payload bytes (17*(i+1)), CRC16, eop.
    task automatic send_data(input int n, input int flip_idx, input int full_from);
        logic [7:0]  pl[$];
        logic [15:0] crc;
        logic [7:0]  b;
        crc = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'((i + 1) * 17);
            pl.push_back(b);
            crc = crc16_model(crc, b);
        end
        crc = ~crc;
        pl.push_back(rev8(crc[15:8]));
        pl.push_back(rev8(crc[7:0]));
        if (flip_idx >= 0) pl[flip_idx] = pl[flip_idx] ^ 8'h01;
        put_byte(8'h80);
        put_byte(8'hC3);
        for (int i = 0; i < pl.size(); i++) begin
            if (full_from >= 0 && i >= full_from) buffer_full = 1'b1;
            put_byte(pl[i]);
        end
        put_eop();
        buffer_full = 1'b0;
        settle();
    endtask

    int s_mark, r_mark, e_mark;

    task automatic mark();
        s_mark = strobes.size();
        r_mark = n_ready;
        e_mark = n_err;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'h0);
        rst = 1'b0;

        // eop and bit_error in IDLE are ignored
        mark();
        put_eop();
        put_bit_error();
        settle();
        check("idle_ignore_state", 64'(state_val), 64'd0);
        check("idle_ignore_err", 64'(n_err - e_mark), 64'd0);

        // DATA0 with three payload bytes, stepped to watch SYNC/PID acceptance
        mark();
        put_byte(8'h80);
        #1;
        check("sync_active", 64'(rx_transfer_active), 64'd1);
        check("sync_state", 64'(state_val), 64'd1);
        put_byte(8'hC3);
        #1;
        check("pid_data_state", 64'(state_val), 64'd3);
        check("pid_data_packet", 64'(rx_packet), 64'd1);
        put_byte(8'h11);
        put_byte(8'h22);
        put_byte(8'h33);
        begin
            logic [15:0] c;
            c = crc16_model(crc16_model(crc16_model(16'hFFFF, 8'h11), 8'h22), 8'h33);
            c = ~c;
            put_byte(rev8(c[15:8]));
            put_byte(rev8(c[7:0]));
        end
        put_eop();
        settle();
        check("data3_strobes", 64'(strobes.size() - s_mark), 64'd3);
        check("data3_byte0", 64'(strobes[s_mark]), 64'h11);
        check("data3_byte1", 64'(strobes[s_mark + 1]), 64'h22);
        check("data3_byte2", 64'(strobes[s_mark + 2]), 64'h33);
        check("data3_ready", 64'(n_ready - r_mark), 64'd1);
        check("data3_size", 64'(ready_size), 64'd3);
        check("data3_no_err", 64'(n_err - e_mark), 64'd0);
        check("data3_idle", 64'(state_val), 64'd0);
        check("data3_inactive", 64'(rx_transfer_active), 64'd0);

        // ACK handshake
        mark();
        put_byte(8'h80);
        put_byte(8'hD2);
        put_eop();
        settle();
        check("ack_packet", 64'(rx_packet), 64'd2);
        check("ack_ready", 64'(n_ready - r_mark), 64'd1);
        check("ack_no_store", 64'(strobes.size() - s_mark), 64'd0);
        check("ack_size", 64'(ready_size), 64'd0);

        // IN token: addr 05, endp {001,1} = 3
        mark();
        put_byte(8'h80);
        put_byte(8'h69);
        put_byte(8'h85);
        put_byte(8'h01);
        put_eop();
        settle();
        check("in_packet", 64'(rx_packet), 64'd4);
        check("in_addr", 64'(token_addr), 64'h05);
        check("in_endp", 64'(token_endp), 64'h3);
        check("in_ready", 64'(n_ready - r_mark), 64'd1);

        // Malformed PID: error, stay in ERR past extra bytes, leave on eop
        mark();
        put_byte(8'h80);
        put_byte(8'hC7);
        settle();
        check("badpid_err", 64'(n_err - e_mark), 64'd1);
        check("badpid_state", 64'(state_val), 64'd5);
        check("badpid_inactive", 64'(rx_transfer_active), 64'd0);
        put_byte(8'h55);
        settle();
        check("badpid_holds", 64'(state_val), 64'd5);
        put_eop();
        settle();
        check("badpid_idle", 64'(state_val), 64'd0);
        check("badpid_one_err", 64'(n_err - e_mark), 64'd1);
        check("badpid_no_ready", 64'(n_ready - r_mark), 64'd0);

        // Overflow: 65 payload bytes
        mark();
        send_data(65, -1, -1);
        check("ovf_strobes", 64'(strobes.size() - s_mark), 64'd64);
        check("ovf_first", 64'(strobes[s_mark]), 64'h11);
        check("ovf_last", 64'(strobes[s_mark + 63]), 64'h40);
        check("ovf_err", 64'(n_err - e_mark), 64'd1);
        check("ovf_no_ready", 64'(n_ready - r_mark), 64'd0);
        check("ovf_idle", 64'(state_val), 64'd0);

        // Exactly 64 payload bytes is accepted
        mark();
        send_data(64, -1, -1);
        check("max_strobes", 64'(strobes.size() - s_mark), 64'd64);
        check("max_ready", 64'(n_ready - r_mark), 64'd1);
        check("max_size", 64'(ready_size), 64'd64);

        // buffer_full raised when the third payload byte is due for writing
        mark();
        send_data(10, -1, 4);
        check("full_strobes", 64'(strobes.size() - s_mark), 64'd2);
        check("full_err", 64'(n_err - e_mark), 64'd1);
        check("full_no_ready", 64'(n_ready - r_mark), 64'd0);

        // bit_error mid DATA
        mark();
        put_byte(8'h80);
        put_byte(8'hC3);
        put_byte(8'h11);
        put_byte(8'h22);
        put_byte(8'h33);
        put_bit_error();
        settle();
        check("biterr_err", 64'(n_err - e_mark), 64'd1);
        check("biterr_state", 64'(state_val), 64'd5);
        check("biterr_inactive", 64'(rx_transfer_active), 64'd0);
        put_eop();
        settle();
        check("biterr_idle", 64'(state_val), 64'd0);

        // Reset mid DATA clears every output, then a fresh packet works
        put_byte(8'h80);
        put_byte(8'hC3);
        put_byte(8'h11);
        put_byte(8'h22);
        put_byte(8'h33);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_outputs", all_outs(), 64'h0);
        mark();
        send_data(1, -1, -1);
        check("postrst_strobes", 64'(strobes.size() - s_mark), 64'd1);
        check("postrst_ready", 64'(n_ready - r_mark), 64'd1);
        check("postrst_size", 64'(ready_size), 64'd1);

`ifdef USB_RX_CRC_CHECK_EN
        // One payload bit flipped: rejected at eop
        mark();
        send_data(3, 1, -1);
        check("crcbad_err", 64'(n_err - e_mark), 64'd1);
        check("crcbad_no_ready", 64'(n_ready - r_mark), 64'd0);
        check("crcbad_idle", 64'(state_val), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
